// File: rtl/eq_pkg.sv
// Shared constants, address map and FSM state type for the EQ
// coefficient scheduler slice.
package eq_pkg;

  localparam int NUM_COEFFS      = 15;
  localparam int TIMEOUT_DEFAULT = 4096;

  localparam logic signed [15:0] COEFF_ONE = 16'sh4000;

  localparam logic [3:0] LOW_B0  = 4'd0;
  localparam logic [3:0] LOW_B1  = 4'd1;
  localparam logic [3:0] LOW_B2  = 4'd2;
  localparam logic [3:0] LOW_A1  = 4'd3;
  localparam logic [3:0] LOW_A2  = 4'd4;
  localparam logic [3:0] MID_B0  = 4'd5;
  localparam logic [3:0] MID_B1  = 4'd6;
  localparam logic [3:0] MID_B2  = 4'd7;
  localparam logic [3:0] MID_A1  = 4'd8;
  localparam logic [3:0] MID_A2  = 4'd9;
  localparam logic [3:0] HIGH_B0 = 4'd10;
  localparam logic [3:0] HIGH_B1 = 4'd11;
  localparam logic [3:0] HIGH_B2 = 4'd12;
  localparam logic [3:0] HIGH_A1 = 4'd13;
  localparam logic [3:0] HIGH_A2 = 4'd14;
  localparam logic [3:0] ADDR_INVALID = 4'd15;

  typedef enum logic [1:0] {
    IDLE,
    PENDING,
    SWAP
  } state_t;

  // Passthrough biquad: b0 = 1.0, everything else 0.
  function automatic logic signed [15:0] coeff_rst(input int idx);
    return ((idx % 5) == 0) ? COEFF_ONE : 16'sh0000;
  endfunction

endpackage

// File: rtl/lrclk_edge_sync.sv
// Brings the audio L/R clock into the clk domain (2 flops) and
// flags its rising edge, i.e. the start of each left sample.
// Ports: clk, reset (sync, active-low), l_r_clk (async in),
//        lr_rise (one clk-cycle pulse per frame boundary).
module lrclk_edge_sync (
  input  logic clk,
  input  logic reset,
  input  logic l_r_clk,
  output logic lr_rise
);

  logic [1:0] r_sync;
  logic       r_prev;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_sync <= 2'b00;
      r_prev <= 1'b0;
    end else begin
      r_sync <= {r_sync[0], l_r_clk};
      r_prev <= r_sync[1];
    end
  end

  assign lr_rise = r_sync[1] & ~r_prev;

endmodule

// File: rtl/eq_coeff_scheduler.sv
// Double-buffered 3-band biquad coefficient bank: host writes a
// shadow bank; a commit swaps it live on the next L/R frame edge.
// Ports: clk, reset (sync, active-low), l_r_clk, wr_valid/wr_ready/
//   wr_addr/wr_data (shadow writes), commit_req, commit_done, busy,
//   addr_err, timeout_err, and the 15 live coefficients.
module eq_coeff_scheduler
  import eq_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = TIMEOUT_DEFAULT
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               l_r_clk,
  input  logic               wr_valid,
  output logic               wr_ready,
  input  logic [3:0]         wr_addr,
  input  logic signed [15:0] wr_data,
  input  logic               commit_req,
  output logic               commit_done,
  output logic               busy,
  output logic               addr_err,
  output logic               timeout_err,
  output logic signed [15:0] low_b0,
  output logic signed [15:0] low_b1,
  output logic signed [15:0] low_b2,
  output logic signed [15:0] low_a1,
  output logic signed [15:0] low_a2,
  output logic signed [15:0] mid_b0,
  output logic signed [15:0] mid_b1,
  output logic signed [15:0] mid_b2,
  output logic signed [15:0] mid_a1,
  output logic signed [15:0] mid_a2,
  output logic signed [15:0] high_b0,
  output logic signed [15:0] high_b1,
  output logic signed [15:0] high_b2,
  output logic signed [15:0] high_a1,
  output logic signed [15:0] high_a2
);

  localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  state_t             r_state;
  logic [CW-1:0]      r_cnt;
  logic signed [15:0] r_shadow [NUM_COEFFS];
  logic signed [15:0] r_active [NUM_COEFFS];
  logic               r_wr_ready;
  logic               r_commit_done;
  logic               r_busy;
  logic               r_addr_err;
  logic               r_timeout_err;

  logic w_rise;
  logic w_wr_fire;

  lrclk_edge_sync u_sync (
    .clk     (clk),
    .reset   (reset),
    .l_r_clk (l_r_clk),
    .lr_rise (w_rise)
  );

  assign w_wr_fire = wr_valid & r_wr_ready;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state       <= IDLE;
      r_cnt         <= '0;
      r_wr_ready    <= 1'b1;
      r_commit_done <= 1'b0;
      r_busy        <= 1'b0;
      r_addr_err    <= 1'b0;
      r_timeout_err <= 1'b0;
      for (int i = 0; i < NUM_COEFFS; i++) begin
        r_shadow[i] <= coeff_rst(i);
        r_active[i] <= coeff_rst(i);
      end
    end else begin
      r_commit_done <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (commit_req) begin
            r_state       <= PENDING;
            r_busy        <= 1'b1;
            r_wr_ready    <= 1'b0;
            r_cnt         <= '0;
            r_addr_err    <= 1'b0;
            r_timeout_err <= 1'b0;
          end
        end
        PENDING: begin
          // A frame edge wins over a same-cycle timeout.
          if (w_rise || (r_cnt == CNT_LAST)) begin
            r_state       <= SWAP;
            r_active      <= r_shadow;
            r_commit_done <= 1'b1;
            if (!w_rise) r_timeout_err <= 1'b1;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        SWAP: begin
          r_state    <= IDLE;
          r_busy     <= 1'b0;
          r_wr_ready <= 1'b1;
        end
        default: begin
          r_state    <= IDLE;
          r_busy     <= 1'b0;
          r_wr_ready <= 1'b1;
        end
      endcase
      // After the FSM so a write coinciding with commit_req lands
      // in the shadow bank (and its error) before the swap.
      if (w_wr_fire) begin
        if (wr_addr == ADDR_INVALID) r_addr_err <= 1'b1;
        else r_shadow[wr_addr] <= wr_data;
      end
    end
  end

  assign wr_ready    = r_wr_ready;
  assign commit_done = r_commit_done;
  assign busy        = r_busy;
  assign addr_err    = r_addr_err;
  assign timeout_err = r_timeout_err;

  assign low_b0  = r_active[LOW_B0];
  assign low_b1  = r_active[LOW_B1];
  assign low_b2  = r_active[LOW_B2];
  assign low_a1  = r_active[LOW_A1];
  assign low_a2  = r_active[LOW_A2];
  assign mid_b0  = r_active[MID_B0];
  assign mid_b1  = r_active[MID_B1];
  assign mid_b2  = r_active[MID_B2];
  assign mid_a1  = r_active[MID_A1];
  assign mid_a2  = r_active[MID_A2];
  assign high_b0 = r_active[HIGH_B0];
  assign high_b1 = r_active[HIGH_B1];
  assign high_b2 = r_active[HIGH_B2];
  assign high_a1 = r_active[HIGH_A1];
  assign high_a2 = r_active[HIGH_A2];

endmodule

// File: tb/tb_eq_coeff_scheduler.sv
// Directed bench for eq_coeff_scheduler: reset, frame-aligned
// swap, coincident write/commit, timeout, bad address, reset abort.
module tb_eq_coeff_scheduler;

  logic clk = 1'b0;
  logic reset;
  logic l_r_clk;
  logic wr_valid;
  logic wr_ready;
  logic [3:0] wr_addr;
  logic signed [15:0] wr_data;
  logic commit_req;
  logic commit_done;
  logic busy;
  logic addr_err;
  logic timeout_err;
  logic signed [15:0] act [15];

  int checks = 0;
  int errors = 0;
  logic signed [15:0] exp_c [15];

  always #5 clk = ~clk;

  eq_coeff_scheduler #(.TIMEOUT_CYCLES(16)) dut (
    .clk         (clk),
    .reset       (reset),
    .l_r_clk     (l_r_clk),
    .wr_valid    (wr_valid),
    .wr_ready    (wr_ready),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .commit_req  (commit_req),
    .commit_done (commit_done),
    .busy        (busy),
    .addr_err    (addr_err),
    .timeout_err (timeout_err),
    .low_b0      (act[0]),
    .low_b1      (act[1]),
    .low_b2      (act[2]),
    .low_a1      (act[3]),
    .low_a2      (act[4]),
    .mid_b0      (act[5]),
    .mid_b1      (act[6]),
    .mid_b2      (act[7]),
    .mid_a1      (act[8]),
    .mid_a2      (act[9]),
    .high_b0     (act[10]),
    .high_b1     (act[11]),
    .high_b2     (act[12]),
    .high_a1     (act[13]),
    .high_a2     (act[14])
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  task automatic check_bank(input string tag);
    for (int i = 0; i < 15; i++)
      check($sformatf("%s[%0d]", tag, i),
            32'(act[i]), 32'(exp_c[i]));
  endtask

  task automatic exp_reset();
    for (int i = 0; i < 15; i++)
      exp_c[i] = ((i % 5) == 0) ? 16'sh4000 : 16'sh0000;
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    reset      = 1'b0;
    l_r_clk    = 1'b0;
    wr_valid   = 1'b0;
    wr_addr    = 4'd0;
    wr_data    = 16'sh0000;
    commit_req = 1'b0;
    exp_reset();
    step(3);
    reset = 1'b1;
    step(1);

    // Reset state
    check_bank("rst");
    check("rst wr_ready", 32'(wr_ready), 32'd1);
    check("rst busy", 32'(busy), 32'd0);
    check("rst addr_err", 32'(addr_err), 32'd0);
    check("rst timeout_err", 32'(timeout_err), 32'd0);
    check("rst commit_done", 32'(commit_done), 32'd0);

    // Atomic frame-aligned swap of mid_b0
    wr_valid = 1'b1; wr_addr = 4'd5; wr_data = 16'sh1234;
    step(1);
    wr_valid = 1'b0;
    check("wr no live change", 32'(act[5]), 32'h4000);
    commit_req = 1'b1;
    step(1);
    commit_req = 1'b0;
    check("pend busy", 32'(busy), 32'd1);
    check("pend wr_ready", 32'(wr_ready), 32'd0);
    step(3);
    check("pend hold", 32'(act[5]), 32'h4000);
    l_r_clk = 1'b1;
    for (int k = 1; k <= 2; k++) begin
      step(1);
      check($sformatf("sync hold %0d", k), 32'(act[5]), 32'h4000);
      check($sformatf("sync done %0d", k), 32'(commit_done), 32'd0);
    end
    step(1);
    exp_c[5] = 16'sh1234;
    check("swap done", 32'(commit_done), 32'd1);
    check_bank("swap");
    check("swap busy", 32'(busy), 32'd1);
    step(1);
    check("swap done pulse", 32'(commit_done), 32'd0);
    check("swap idle busy", 32'(busy), 32'd0);
    check("swap idle ready", 32'(wr_ready), 32'd1);
    check("swap no tmo", 32'(timeout_err), 32'd0);

    // Coincident write + commit
    l_r_clk = 1'b0;
    step(3);
    wr_valid = 1'b1; wr_addr = 4'd14; wr_data = 16'shC000;
    commit_req = 1'b1;
    step(1);
    wr_valid = 1'b0; commit_req = 1'b0;
    check("coin busy", 32'(busy), 32'd1);
    check("coin hold", 32'(act[14]), 32'h0000);
    l_r_clk = 1'b1;
    step(3);
    exp_c[14] = 16'shC000;
    check("coin done", 32'(commit_done), 32'd1);
    check_bank("coin");
    step(1);

    // Timeout with l_r_clk held high
    wr_valid = 1'b1; wr_addr = 4'd0; wr_data = 16'sh2000;
    step(1);
    wr_valid = 1'b0;
    commit_req = 1'b1;
    step(1);
    commit_req = 1'b0;
    for (int k = 1; k <= 15; k++) begin
      step(1);
      check($sformatf("tmo wait %0d", k), 32'(commit_done), 32'd0);
    end
    step(1);
    exp_c[0] = 16'sh2000;
    check("tmo done", 32'(commit_done), 32'd1);
    check("tmo err", 32'(timeout_err), 32'd1);
    check_bank("tmo");
    step(1);
    check("tmo idle busy", 32'(busy), 32'd0);
    check("tmo sticky", 32'(timeout_err), 32'd1);

    // Bad address: dropped, flagged, cleared by next commit
    l_r_clk = 1'b0;
    wr_valid = 1'b1; wr_addr = 4'd15; wr_data = 16'sh7777;
    step(1);
    wr_valid = 1'b0;
    check("bad addr_err", 32'(addr_err), 32'd1);
    check("bad ready", 32'(wr_ready), 32'd1);
    check_bank("bad live");
    step(2);
    commit_req = 1'b1;
    step(1);
    commit_req = 1'b0;
    check("bad clr addr_err", 32'(addr_err), 32'd0);
    check("bad clr tmo", 32'(timeout_err), 32'd0);
    l_r_clk = 1'b1;
    step(3);
    check("bad done", 32'(commit_done), 32'd1);
    check_bank("bad swap");
    step(1);

    // Reset while PENDING aborts the commit
    l_r_clk = 1'b0;
    step(3);
    wr_valid = 1'b1; wr_addr = 4'd10; wr_data = 16'sh1111;
    step(1);
    wr_valid = 1'b0;
    commit_req = 1'b1;
    step(1);
    commit_req = 1'b0;
    step(1);
    check("abort pend busy", 32'(busy), 32'd1);
    reset = 1'b0;
    step(2);
    reset = 1'b1;
    exp_reset();
    l_r_clk = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      step(1);
      check($sformatf("abort no done %0d", k),
            32'(commit_done), 32'd0);
    end
    check_bank("abort");
    check("abort busy", 32'(busy), 32'd0);
    check("abort ready", 32'(wr_ready), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
